// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT_SPACE
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_EXC,
    REDIR_BR,
    REDIR_JMP
  } redir_src_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between the fetch FSM and decode.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: credit-limited memory requests, redirects
// with squash of in-flight data, and a 2-entry buffer toward decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        exc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         squash_q, squash_d;

  redir_src_e   redir_src;
  logic         redirect;
  logic [31:0]  redir_tgt;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_wdata;
  logic         fills_last;

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
  assign fifo_pop    = instr_valid && instr_ready;
  assign fifo_wdata  = '{instr: imem_rdata, pc: pc_q};
  // While squashing, the bus must keep showing the abandoned address until ack.
  assign imem_addr   = squash_q ? hold_q : pc_q;

  always_comb begin
    redir_src = REDIR_NONE;
    if (exc) begin
      redir_src = REDIR_EXC;
    end else if (br_taken) begin
      redir_src = REDIR_BR;
    end else if (jmp) begin
      redir_src = REDIR_JMP;
    end
    redirect = (redir_src != REDIR_NONE);
    case (redir_src)
      REDIR_EXC: redir_tgt = word_align(EXC_VECTOR);
      REDIR_BR:  redir_tgt = word_align(br_target);
      REDIR_JMP: redir_tgt = word_align(jmp_target);
      default:   redir_tgt = pc_q;
    endcase
  end

  // Occupancy after this cycle's push would reach two entries.
  assign fills_last = (fifo_full && fifo_pop) ||
                      (!fifo_empty && !fifo_full && !fifo_pop);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    squash_d   = squash_q;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
          end else if (!redirect) begin
            fifo_push = 1'b1;
            pc_d      = pc_q + 32'd4;
            if (fills_last) begin
              state_d = ST_WAIT_SPACE;
            end
          end
        end else if (redirect && !squash_q) begin
          squash_d = 1'b1;
          hold_d   = pc_q;
        end
      end
      ST_WAIT_SPACE: begin
        if (redirect || fifo_pop) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (redirect) begin
      fifo_flush = 1'b1;
      pc_d       = redir_tgt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      squash_q <= squash_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a queue-based model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ack, exc, br_taken, jmp;
  logic        instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, br_target, jmp_target, instr, instr_pc;
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_instr, d2_pc;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .exc(exc),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .imem_req(d2_req), .imem_addr(d2_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .exc(exc),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .instr_valid(d2_valid), .instr_ready(instr_ready), .instr(d2_instr), .instr_pc(d2_pc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pc, pending squash, and the decode buffer as a queue.
  bit          m_boot;
  bit          m_squash;
  logic [31:0] m_pc;
  logic [31:0] m_held;
  logic [63:0] m_q[$];

  bit          chk2 = 1'b0;
  logic [31:0] exp2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ack, input bit rdy);
    imem_ack    = ack;
    instr_ready = rdy;
    imem_rdata  = $urandom;
    exc         = 1'b0;
    br_taken    = 1'b0;
    jmp         = 1'b0;
    br_target   = 32'h0;
    jmp_target  = 32'h0;
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    m_boot   = 1'b1;
    m_squash = 1'b0;
    m_pc     = rpc;
    m_held   = 32'h0;
    m_q.delete();
  endtask

  // One clock cycle: compare at the falling edge, then advance the model.
  task automatic cyc();
    bit          exp_req, pop, redir, comp;
    logic [31:0] tgt, rdata;
    logic [63:0] head;
    @(negedge clk);
    exp_req = !m_boot && (m_q.size() < 2);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_squash ? m_held : m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      head = m_q[0];
      chk("instr", instr, head[63:32]);
      chk("instr_pc", instr_pc, head[31:0]);
    end
    if (chk2 && exp_req) begin
      chk("wrap_addr", d2_addr, exp2);
      exp2 = exp2 + 32'd4;
    end
    pop   = (m_q.size() > 0) && instr_ready;
    redir = exc || br_taken || jmp;
    tgt   = exc ? 32'h80 : (br_taken ? br_target : jmp_target);
    comp  = exp_req && imem_ack;
    rdata = imem_rdata;
    @(posedge clk);
    m_boot = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (redir) begin
      m_q.delete();
      if (comp) m_squash = 1'b0;
      else if (exp_req && !m_squash) begin
        m_squash = 1'b1;
        m_held   = m_pc;
      end
      m_pc = tgt;
    end else if (comp) begin
      if (m_squash) m_squash = 1'b0;
      else begin
        m_q.push_back({rdata, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_addr2", d2_addr, 32'hFFFF_FFF8);
    model_reset(32'h0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0);
    model_reset(32'h0);

    // Streaming with zero-wait memory; second instance shows address wrap.
    do_reset();
    drive(1'b1, 1'b1);
    exp2 = 32'hFFFF_FFF8;
    chk2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_rdata = $urandom;
      cyc();
    end
    chk2 = 1'b0;
    chk("stream_pc", instr_pc, 32'h20);

    // Decode stalled: two pushes, then the request drops until a pop.
    do_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      imem_rdata = $urandom;
      cyc();
    end
    chk("stall_req", {31'b0, imem_req}, 32'h0);
    chk("stall_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    cyc();
    chk("resume_req", {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h8);

    // Branch while a slow request is outstanding.
    do_reset();
    drive(1'b0, 1'b1);
    cyc();
    cyc();
    br_taken  = 1'b1;
    br_target = 32'h100;
    cyc();
    br_taken = 1'b0;
    chk("squash_hold_addr", imem_addr, 32'h0);
    cyc();
    imem_ack = 1'b1;
    cyc();
    chk("squash_next_addr", imem_addr, 32'h100);
    chk("squash_dropped", {31'b0, instr_valid}, 32'h0);
    cyc();
    cyc();

    // All three redirect sources at once with a full buffer.
    do_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc();
    exc        = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h200;
    jmp        = 1'b1;
    jmp_target = 32'h300;
    cyc();
    drive(1'b1, 1'b0);
    chk("prio_addr", imem_addr, 32'h80);
    chk("prio_flush", {31'b0, instr_valid}, 32'h0);
    cyc();
    cyc();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      r          = $urandom_range(0, 24);
      exc        = (r == 0);
      br_taken   = (r == 1) || (r == 3);
      jmp        = (r == 2) || (r == 3);
      br_target  = $urandom & 32'hFFFF_FFFC;
      jmp_target = $urandom & 32'hFFFF_FFFC;
      cyc();
    end

    // Reset in the middle of a request; stale ack after release is ignored.
    do_reset();
    drive(1'b0, 1'b1);
    cyc();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    model_reset(32'h0);
    imem_ack = 1'b1;
    reset    = 1'b1;
    cyc();
    cyc();
    chk("midrst_first_pc", instr_pc, 32'h0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
